hex_token_decoder: RTL and testbench
====================================

Name: hex_token_decoder

Overview:
- Decodes a stream of ASCII hex characters into binary words. It is the inverse of the hexdigit nibble-to-ASCII encoding.
- Sits between a byte source (UART RX via fifo) and a command/register consumer.
- Accumulates digits into a WIDTH-bit value and emits one word per delimiter-terminated token. Bad tokens are flagged and discarded.

Parameters:
WIDTH, 32, output word width in bits; must be a multiple of 4, minimum 4
MAX_DIGITS, WIDTH/4, maximum hex digits accepted per token
CNT_BITS, CLOG2(MAX_DIGITS+1), width of the digit counter and of out_digits

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
in_data  input  8  ASCII character
in_strobe  input  1  character valid; consumed on a cycle where in_strobe && in_ready
in_ready  output  1  decoder can accept a character; combinational, = (state != EMIT)
out_data  output  WIDTH  decoded word; valid while out_valid
out_digits  output  CNT_BITS  number of digits in the emitted token
out_valid  output  1  word available; held until accepted
out_ready  input  1  consumer accepts the word on out_valid && out_ready
err_strobe  output  1  one-cycle pulse when a token is rejected
err_count  output  8  saturating count of rejected tokens

Behaviour:
- Reset (async) values: state IDLE, accumulator 0, digit count 0, out_data 0, out_digits 0, out_valid 0, err_strobe 0, err_count 0. in_ready = 1 during and after reset.
- Character classes:
  - digit: '0'-'9', 'a'-'f', 'A'-'F'; nibble = ASCII value decoded.
  - delimiter: 0x20 space, 0x0D CR, 0x0A LF, 0x2C comma.
  - invalid: everything else.
- IDLE:
  - digit -> acc = nibble, count = 1, go to ACCUM.
  - delimiter -> ignored; an empty token produces no output.
  - invalid -> err_strobe, go to SKIP.
- ACCUM:
  - digit with count < MAX_DIGITS -> acc = {acc[WIDTH-5:0], nibble}, count += 1.
  - digit with count == MAX_DIGITS -> overflow: err_strobe, go to SKIP.
  - delimiter -> out_data = acc, out_digits = count, out_valid = 1, go to EMIT.
  - invalid -> err_strobe, go to SKIP.
- EMIT:
  - in_ready = 0; out_data and out_digits are stable.
  - On out_valid && out_ready: out_valid = 0, acc = 0, count = 0, go to IDLE next cycle.
  - A character offered during EMIT is not consumed; the upstream must hold it.
- SKIP:
  - Discard all characters until a delimiter, then go to IDLE.
  - No output for the rejected token; further invalid characters raise no additional err_strobe.
- Latency: delimiter consumed in cycle N -> out_valid high in cycle N+1. Maximum throughput is one word per (digits + 1 + 1) cycles with out_ready held high.
- err_strobe: registered, high exactly one cycle after the offending character is consumed.
- err_count: increments on each err_strobe; saturates at 255, no wrap.
- Fewer than MAX_DIGITS digits: the word is zero-extended (right-aligned).
- in_strobe while in_ready = 0: no state change and no error.
- Reset mid-token or during EMIT: everything returns to reset values; the pending word is lost and out_valid drops asynchronously.

Optional Feature:
HEX_TOKEN_DECODER_0X_PREFIX_EN
- Defined:
  - In ACCUM with count == 1 and acc == 0, 'x' or 'X' clears count to 0 and stays in ACCUM (prefix state).
  - A delimiter immediately after the prefix (count == 0) is an error: err_strobe, then IDLE.
  - The prefix does not count toward MAX_DIGITS.
  - 'x' anywhere else is invalid.
- Not defined: 'x'/'X' is always invalid; "0x1F" is rejected.

Test Plan:
1. WIDTH=32, send "1A2b\n" with out_ready=1 -> out_valid one cycle after '\n', out_data=0x00001A2B, out_digits=4, err_count=0.
2. Send "DEADBEEF " then "123456789 " -> first word out_data=0xDEADBEEF, out_digits=8. On the 9th digit of the second token: err_strobe pulses once and err_count=1; no second word.
3. Send "12G4,55\r" -> err_strobe on 'G', '4' discarded, then out_data=0x55, out_digits=2.
4. Send "7 " with out_ready=0 for 10 cycles, then offer "8 " -> in_ready=0 and '8' not consumed while out_valid stays high. Raise out_ready -> word 0x7 accepted, then '8' consumed and decoded as 0x8.
5. Send "  \r\n,," -> no out_valid, no err_strobe. Send "Z " 300 times -> err_count saturates at 255.
6. Assert reset mid-token after "AB" -> outputs return to reset values immediately. Then send "0x10 " -> with HEX_TOKEN_DECODER_0X_PREFIX_EN: out_data=0x10, out_digits=2; without it: err_strobe, no word.

Source files
------------

// File: rtl/hex_token_decoder.sv
// ASCII hex token decoder: turns delimiter-terminated hex digit runs into WIDTH-bit words.
// Optional "0x"/"0X" prefix support is enabled by defining HEX_TOKEN_DECODER_0X_PREFIX_EN.
module hex_token_decoder #(
    parameter int WIDTH      = 32,
    parameter int MAX_DIGITS = WIDTH / 4,
    parameter int CNT_BITS   = $clog2(MAX_DIGITS + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          in_data,
    input  logic                in_strobe,
    output logic                in_ready,
    output logic [WIDTH-1:0]    out_data,
    output logic [CNT_BITS-1:0] out_digits,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                err_strobe,
    output logic [7:0]          err_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2,
        SKIP  = 2'd3
    } state_t;

    localparam logic [CNT_BITS-1:0] MAX_CNT = CNT_BITS'(MAX_DIGITS);

    state_t              state_q;
    logic [WIDTH-1:0]    acc_q;
    logic [WIDTH-1:0]    acc_d;
    logic [CNT_BITS-1:0] count_q;
    logic [WIDTH-1:0]    out_data_q;
    logic [CNT_BITS-1:0] out_digits_q;
    logic                out_valid_q;
    logic                err_strobe_q;
    logic [7:0]          err_count_q;

    logic [3:0]          nibble_s;
    logic                is_digit_s;
    logic                is_delim_s;
    logic                prefix_ok_s;
    logic                take_s;
    logic                err_event_s;

    // Returns {is_hex_digit, nibble} for one ASCII character.
    function automatic logic [4:0] hex_decode(input logic [7:0] c);
        logic [4:0] r;
        if (c >= 8'h30 && c <= 8'h39) begin
            r = {1'b1, c[3:0]};
        end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
            r = {1'b1, c[3:0] + 4'd9};
        end else begin
            r = 5'd0;
        end
        return r;
    endfunction

    // Character classification and the shifted accumulator candidate.
    always_comb begin
        {is_digit_s, nibble_s} = hex_decode(in_data);
        is_delim_s = (in_data == 8'h20) || (in_data == 8'h0D) ||
                     (in_data == 8'h0A) || (in_data == 8'h2C);
`ifdef HEX_TOKEN_DECODER_0X_PREFIX_EN
        prefix_ok_s = ((in_data == 8'h78) || (in_data == 8'h58)) &&
                      (count_q == CNT_BITS'(1)) && (acc_q == '0);
`else
        prefix_ok_s = 1'b0;
`endif
        take_s = in_strobe && (state_q != EMIT);
        acc_d = acc_q << 3'd4;
        acc_d[3:0] = nibble_s;
    end

    // Decide whether the character consumed this cycle rejects the current token.
    always_comb begin
        err_event_s = 1'b0;
        if (take_s) begin
            case (state_q)
                IDLE:    err_event_s = !is_digit_s && !is_delim_s;
                ACCUM:   err_event_s = (is_digit_s && (count_q == MAX_CNT)) ||
                                       (is_delim_s && (count_q == '0)) ||
                                       (!is_digit_s && !is_delim_s && !prefix_ok_s);
                default: err_event_s = 1'b0;
            endcase
        end else begin
            err_event_s = 1'b0;
        end
    end

    // Token FSM with registered word, error pulse and saturating error counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            count_q      <= '0;
            out_data_q   <= '0;
            out_digits_q <= '0;
            out_valid_q  <= 1'b0;
            err_strobe_q <= 1'b0;
            err_count_q  <= 8'd0;
        end else begin
            err_strobe_q <= err_event_s;
            if (err_event_s && (err_count_q != 8'hFF)) begin
                err_count_q <= err_count_q + 8'd1;
            end
            case (state_q)
                IDLE: begin
                    if (take_s && is_digit_s) begin
                        acc_q   <= WIDTH'(nibble_s);
                        count_q <= CNT_BITS'(1);
                        state_q <= ACCUM;
                    end else if (take_s && !is_delim_s) begin
                        state_q <= SKIP;
                    end
                end
                ACCUM: begin
                    if (take_s) begin
                        if (err_event_s) begin
                            state_q <= is_delim_s ? IDLE : SKIP;
                        end else if (is_digit_s) begin
                            acc_q   <= acc_d;
                            count_q <= count_q + CNT_BITS'(1);
                        end else if (is_delim_s) begin
                            out_data_q   <= acc_q;
                            out_digits_q <= count_q;
                            out_valid_q  <= 1'b1;
                            state_q      <= EMIT;
                        end else begin
                            // Prefix accepted: digits after it count from zero.
                            count_q <= '0;
                        end
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        acc_q       <= '0;
                        count_q     <= '0;
                        state_q     <= IDLE;
                    end
                end
                SKIP: begin
                    if (take_s && is_delim_s) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready   = (state_q != EMIT);
    assign out_data   = out_data_q;
    assign out_digits = out_digits_q;
    assign out_valid  = out_valid_q;
    assign err_strobe = err_strobe_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_hex_token_decoder.sv
// Self-checking bench for hex_token_decoder: token-level reference model compared every cycle,
// plus literal expectations for the directed scenarios.
module tb_hex_token_decoder;

    localparam int W    = 32;
    localparam int MAXD = 8;
    localparam int CB   = 4;
`ifdef HEX_TOKEN_DECODER_0X_PREFIX_EN
    localparam bit PFX = 1'b1;
`else
    localparam bit PFX = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    in_data = 8'h00;
    logic          in_strobe = 1'b0;
    logic          in_ready;
    logic [W-1:0]  out_data;
    logic [CB-1:0] out_digits;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          err_strobe;
    logic [7:0]    err_count;

    int n_checks = 0;
    int n_errors = 0;

    hex_token_decoder #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_strobe(in_strobe),
        .in_ready(in_ready), .out_data(out_data), .out_digits(out_digits),
        .out_valid(out_valid), .out_ready(out_ready), .err_strobe(err_strobe),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (token strings, not states) ----------------
    byte unsigned tok[$];
    bit           m_bad, m_valid, m_err, m_took;
    logic [31:0]  m_data;
    int           m_digits, m_cnt;

    function automatic int hexnib(input logic [7:0] c);
        string digs = "0123456789abcdef";
        logic [7:0] lc = (c >= 8'h41 && c <= 8'h5A) ? c + 8'h20 : c;
        for (int i = 0; i < 16; i++) if (digs[i] == lc) return i;
        return -1;
    endfunction

    function automatic bit is_delim(input logic [7:0] c);
        return c == 8'h20 || c == 8'h0D || c == 8'h0A || c == 8'h2C;
    endfunction

    function automatic bit has_prefix();
        return PFX && tok.size() >= 2 && (tok[1] == 8'h78 || tok[1] == 8'h58);
    endfunction

    function automatic void reject();
        m_err = 1'b1;
        if (m_cnt < 255) m_cnt++;
        m_bad = 1'b1;
        tok.delete();
    endfunction

    function automatic void model_char(input logic [7:0] c);
        int start;
        if (is_delim(c)) begin
            if (!m_bad && tok.size() > 0) begin
                start = has_prefix() ? 2 : 0;
                if (start == 2 && tok.size() == 2) begin
                    reject();
                end else begin
                    m_data = 0;
                    for (int i = start; i < tok.size(); i++) m_data = m_data * 16 + hexnib(tok[i]);
                    m_digits = tok.size() - start;
                    m_valid = 1'b1;
                end
            end
            m_bad = 1'b0;
            tok.delete();
        end else if (!m_bad) begin
            start = has_prefix() ? 2 : 0;
            if (PFX && (c == 8'h78 || c == 8'h58) && tok.size() == 1 && tok[0] == 8'h30)
                tok.push_back(c);
            else if (hexnib(c) < 0)
                reject();
            else if (tok.size() - start == MAXD)
                reject();
            else
                tok.push_back(c);
        end
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            tok.delete();
            m_bad = 0; m_valid = 0; m_err = 0; m_took = 0;
            m_data = 0; m_digits = 0; m_cnt = 0;
        end else begin
            m_err = 0;
            m_took = 0;
            if (in_strobe && !m_valid) begin
                m_took = 1;
                model_char(in_data);
            end else if (m_valid && out_ready) begin
                m_valid = 0;
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        check("in_ready", {31'd0, in_ready}, {31'd0, !m_valid});
        check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        if (m_valid) begin
            check("out_data", out_data, m_data);
            check("out_digits", {28'd0, out_digits}, m_digits);
        end
        check("err_strobe", {31'd0, err_strobe}, {31'd0, m_err});
        check("err_count", {24'd0, err_count}, m_cnt);
    end

    // Record accepted words for the literal checks.
    logic [31:0] got_data[$];
    int          got_digits[$];
    always @(posedge clk) begin
        if (!reset && out_valid && out_ready) begin
            got_data.push_back(out_data);
            got_digits.push_back(int'(out_digits));
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_char(input logic [7:0] c);
        in_data = c;
        in_strobe = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk); #1;
            if (m_took) begin
                in_strobe = 1'b0;
                return;
            end
        end
        in_strobe = 1'b0;
        check("send_timeout", 32'd1, 32'd0);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i]);
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_err_count", {24'd0, err_count}, 32'd0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        @(posedge clk); #1;

        // 1: basic mixed-case token
        got_data.delete(); got_digits.delete();
        send_str("1A2b\n");
        check("t1_valid_next", {31'd0, out_valid}, 32'd1);
        settle();
        check("t1_words", got_data.size(), 32'd1);
        if (got_data.size() == 1) begin
            check("t1_data", got_data[0], 32'h00001A2B);
            check("t1_digits", got_digits[0], 32'd4);
        end
        check("t1_errcnt", {24'd0, err_count}, 32'd0);

        // 2: full-width word, then overflow
        got_data.delete(); got_digits.delete();
        send_str("DEADBEEF ");
        send_str("123456789 ");
        settle();
        check("t2_words", got_data.size(), 32'd1);
        if (got_data.size() == 1) begin
            check("t2_data", got_data[0], 32'hDEADBEEF);
            check("t2_digits", got_digits[0], 32'd8);
        end
        check("t2_errcnt", {24'd0, err_count}, 32'd1);

        // 3: invalid char discards rest of token, next token fine
        got_data.delete(); got_digits.delete();
        send_str("12G4,55\r");
        settle();
        check("t3_words", got_data.size(), 32'd1);
        if (got_data.size() == 1) begin
            check("t3_data", got_data[0], 32'h00000055);
            check("t3_digits", got_digits[0], 32'd2);
        end
        check("t3_errcnt", {24'd0, err_count}, 32'd2);

        // 4: backpressure holds the word and blocks input
        got_data.delete(); got_digits.delete();
        out_ready = 1'b0;
        send_str("7 ");
        in_data = 8'h38;
        in_strobe = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("t4_in_ready_low", {31'd0, in_ready}, 32'd0);
        check("t4_valid_held", {31'd0, out_valid}, 32'd1);
        check("t4_data_held", out_data, 32'h7);
        out_ready = 1'b1;
        send_char(8'h38);
        send_char(8'h20);
        settle();
        check("t4_words", got_data.size(), 32'd2);
        if (got_data.size() == 2) begin
            check("t4_first", got_data[0], 32'h7);
            check("t4_second", got_data[1], 32'h8);
        end

        // 5: empty tokens, then error counter saturation
        got_data.delete(); got_digits.delete();
        send_str("  \r\n,,");
        settle();
        check("t5_no_words", got_data.size(), 32'd0);
        check("t5_errcnt_same", {24'd0, err_count}, 32'd2);
        for (int i = 0; i < 300; i++) send_str("Z ");
        settle();
        check("t5_saturated", {24'd0, err_count}, 32'd255);

        // 6: async reset while a word is pending, then prefixed token
        out_ready = 1'b0;
        send_str("AB ");
        check("t6_pending", {31'd0, out_valid}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("t6_rst_valid", {31'd0, out_valid}, 32'd0);
        check("t6_rst_errcnt", {24'd0, err_count}, 32'd0);
        check("t6_rst_ready", {31'd0, in_ready}, 32'd1);
        check("t6_rst_data", out_data, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        got_data.delete(); got_digits.delete();
        send_str("0x10 ");
        settle();
        if (PFX) begin
            check("t6_pfx_words", got_data.size(), 32'd1);
            if (got_data.size() == 1) begin
                check("t6_pfx_data", got_data[0], 32'h10);
                check("t6_pfx_digits", got_digits[0], 32'd2);
            end
            check("t6_pfx_errcnt", {24'd0, err_count}, 32'd0);
        end else begin
            check("t6_nopfx_words", got_data.size(), 32'd0);
            check("t6_nopfx_errcnt", {24'd0, err_count}, 32'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
